// File: rtl/coin_pulser_pkg.sv
// coin_pulser_pkg
// Shared types and sizing helpers for the coin pulse conditioner.
//   cp_state_t    : output sequencer states (IDLE, PULSE, GAP)
//   cp_cnt_width  : width of a down-counter that holds max(a,b,c)
//   CP_TCNT_W     : tick-counter width for the default timing parameters
package coin_pulser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } cp_state_t;

    // Bits needed to hold the largest of three millisecond counts.
    function automatic int cp_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    localparam int CP_TCNT_W = cp_cnt_width(100, 100, 5);

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce
// Debounces the raw coin request against the 1 ms timebase and emits a
// one-cycle press strobe on each accepted rising edge.
// Ports:
//   clk_sys : system clock
//   reset   : synchronous, active-high reset
//   tick    : one-cycle timebase strobe
//   din     : raw request, synchronous to clk_sys
//   level   : debounced level
//   press   : one cycle high when the debounced level rises
module coin_debounce
    import coin_pulser_pkg::*;
#(
    parameter int DEB_MS = 5
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          press_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (din == level_reg) begin
                // Any agreeing sample restarts the stability window.
                cnt_reg <= '0;
            end else if (tick) begin
                if (cnt_reg == CW'(DEB_MS - 1)) begin
                    level_reg <= ~level_reg;
                    cnt_reg   <= '0;
                    // Only the 0->1 transition counts as a press.
                    press_reg <= ~level_reg;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/coin_pulser.sv
// coin_pulser
// Turns the merged coin request into clean fixed-width coin pulses:
// debounce, count presses into a saturating credit queue, then replay each
// credit as one pulse followed by a mandatory low gap.
// Optional feature macro: COIN_LOCKOUT_EN (adds the lockout input; presses
// seen while it is high are discarded and counted).
// Ports:
//   clk_sys  : system clock
//   reset    : synchronous, active-high reset
//   ce_6m    : clock enable feeding the 1 ms prescaler
//   hold     : 1 = do not launch new pulses (ROM download)
//   coin_in  : raw coin request, active high
//   lockout  : (COIN_LOCKOUT_EN only) discard presses while high
//   coin_out : conditioned coin pulse, active high
//   pending  : queued coins not yet emitted
//   overflow : one-cycle strobe, press arrived with the queue full
module coin_pulser
    import coin_pulser_pkg::*;
#(
    parameter int PRESCALE = 6000,
    parameter int DEB_MS   = 5,
    parameter int PULSE_MS = 100,
    parameter int GAP_MS   = 100,
    parameter int QDEPTH   = 7
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        ce_6m,
    input  logic                        hold,
    input  logic                        coin_in,
`ifdef COIN_LOCKOUT_EN
    input  logic                        lockout,
`endif
    output logic                        coin_out,
    output logic [$clog2(QDEPTH+1)-1:0] pending,
    output logic                        overflow
);

    localparam int TW = cp_cnt_width(PULSE_MS, GAP_MS, DEB_MS);
    localparam int PW = $clog2(QDEPTH + 1);
    localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [SW-1:0] pre_reg;
    logic          tick_reg;
    logic          deb_level;
    logic          deb_press;
    logic          accept;

    cp_state_t     state_reg, state_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic          coin_out_reg, coin_out_next;
    logic [PW-1:0] pending_reg, pending_next;
    logic          overflow_reg, overflow_next;
    logic          deq;

    // 1 ms timebase; keeps running during hold so debounce still works.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (ce_6m) begin
                if (pre_reg == SW'(PRESCALE - 1)) begin
                    pre_reg  <= '0;
                    tick_reg <= 1'b1;
                end else begin
                    pre_reg <= pre_reg + SW'(1);
                end
            end
        end
    end

    coin_debounce #(
        .DEB_MS (DEB_MS)
    ) u_debounce (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick    (tick_reg),
        .din     (coin_in),
        .level   (deb_level),
        .press   (deb_press)
    );

`ifdef COIN_LOCKOUT_EN
    // Presses rejected by the lockout latch, kept for visibility.
    logic [7:0] discard_cnt_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            discard_cnt_reg <= '0;
        end else if (deb_press && lockout) begin
            discard_cnt_reg <= discard_cnt_reg + 8'd1;
        end
    end

    assign accept = deb_press && deb_level && !lockout;
`else
    // press is only ever raised together with a high debounced level.
    assign accept = deb_press && deb_level;
`endif

    // Sequencer: launch from IDLE, then time PULSE and GAP on timebase ticks.
    always_comb begin
        state_next    = state_reg;
        tcnt_next     = tcnt_reg;
        coin_out_next = coin_out_reg;
        deq           = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if ((pending_reg != '0) && !hold) begin
                    state_next    = PULSE;
                    coin_out_next = 1'b1;
                    tcnt_next     = TW'(PULSE_MS - 1);
                    deq           = 1'b1;
                end
            end
            PULSE: begin
                if (tick_reg) begin
                    if (tcnt_reg == '0) begin
                        state_next    = GAP;
                        coin_out_next = 1'b0;
                        tcnt_next     = TW'(GAP_MS - 1);
                    end else begin
                        tcnt_next = tcnt_reg - TW'(1);
                    end
                end
            end
            GAP: begin
                if (tick_reg) begin
                    if (tcnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        tcnt_next = tcnt_reg - TW'(1);
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                coin_out_next = 1'b0;
            end
        endcase
    end

    // Credit queue: a press and a dequeue in the same cycle cancel out,
    // so a full queue only overflows when nothing is leaving it.
    always_comb begin
        pending_next  = pending_reg;
        overflow_next = 1'b0;
        if (accept && !deq) begin
            if (pending_reg == PW'(QDEPTH)) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending_reg + PW'(1);
            end
        end else if (!accept && deq) begin
            pending_next = pending_reg - PW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= IDLE;
            tcnt_reg     <= '0;
            coin_out_reg <= 1'b0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tcnt_reg     <= tcnt_next;
            coin_out_reg <= coin_out_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
        end
    end

    assign coin_out = coin_out_reg;
    assign pending  = pending_reg;
    assign overflow = overflow_reg;

endmodule
